// File: rtl/rnn_cell_engine_if.sv
// Streamer/SRAM bus of the RNN cell engine. The engine side takes the master
// modport; the input streamer and the shared weight/output SRAM take the slave.
interface rnn_cell_engine_if #(
  parameter int XBITS = 32,
  parameter int DW    = 20,
  parameter int AW    = 17
) ();
  logic             ready;
  logic [XBITS-1:0] idata;
  logic [DW-1:0]    mdata_r;
  logic             busy;
  logic             i_en;
  logic             mce;
  logic [AW-1:0]    maddr;
  logic [2:0]       msel;
  logic [DW-1:0]    mdata_w;

  modport master (input ready, idata, mdata_r,
                  output busy, i_en, mce, maddr, msel, mdata_w);
  modport slave  (output ready, idata, mdata_r,
                  input busy, i_en, mce, maddr, msel, mdata_w);
endinterface

// File: rtl/rnn_cell_engine.sv
// RNN cell engine: h_t = hardtanh(W*h_(t-1) + U*x_t + b1 + b2) for T timesteps.
// Define RNN_ROUND_EN for round-half-up output scaling instead of truncation.
module rnn_cell_engine #(
  parameter int HID   = 64,
  parameter int XBITS = 32,
  parameter int DW    = 20,
  parameter int FRAC  = 16,
  parameter int AW    = 17,
  parameter int TW    = 11
) (
  input  logic              clk,
  input  logic              reset_n,
  rnn_cell_engine_if.master bus
);

  localparam int JW    = (HID > 1) ? $clog2(HID) : 1;
  localparam int KW    = (XBITS > 1) ? $clog2(XBITS) : 1;
  localparam int IW    = (JW > KW) ? JW : KW;
  localparam int ACC_W = 2 * DW + $clog2(HID + XBITS + 2) + 1;

  localparam logic [2:0] SEL_U   = 3'b000;
  localparam logic [2:0] SEL_B1  = 3'b001;
  localparam logic [2:0] SEL_W   = 3'b010;
  localparam logic [2:0] SEL_B2  = 3'b011;
  localparam logic [2:0] SEL_T   = 3'b100;
  localparam logic [2:0] SEL_OUT = 3'b101;

  localparam logic signed [ACC_W-1:0] ONE        = ACC_W'(1) <<< FRAC;
  localparam logic        [DW-1:0]    ONE_DW     = DW'(1) << FRAC;
  localparam logic        [DW-1:0]    NEG_ONE_DW = DW'(0) - ONE_DW;

  typedef enum logic [3:0] {
    S_IDLE, S_LDT, S_LDW, S_GETX, S_XW, S_B1, S_MW, S_MU, S_B2, S_WB, S_DONE
  } state_t;

  state_t           state_q;
  logic             busy_q, i_en_q;
  logic [AW-1:0]    maddr_q;
  logic [2:0]       msel_q;
  logic [DW-1:0]    mdata_w_q;
  logic [TW-1:0]    t_q, t_max_q, t_inc;
  logic [JW-1:0]    j_q;
  logic [IW-1:0]    cnt_q, cnt_inc;
  logic [1:0]       wb_cnt_q;
  logic [XBITS-1:0] x_q;
  logic signed [DW-1:0] h_old_q [HID];
  logic signed [DW-1:0] h_new_q [HID];

  // Read-data pipeline: what was addressed last cycle is on mdata_r now.
  logic [2:0]              rd_sel_q;
  logic [IW-1:0]           rd_idx_q;
  logic signed [ACC_W-1:0] acc_q, acc_d, rd_ext, acc_r, y_full;
  logic signed [2*DW-1:0]  prod;
  logic [DW-1:0]           y;

  assign cnt_inc = cnt_q + 1'b1;
  assign t_inc   = t_q + 1'b1;

  assign bus.busy    = busy_q;
  assign bus.mce     = busy_q;
  assign bus.i_en    = i_en_q;
  assign bus.maddr   = maddr_q;
  assign bus.msel    = msel_q;
  assign bus.mdata_w = mdata_w_q;

  // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    rd_ext = ACC_W'(signed'(bus.mdata_r));
    prod   = signed'(bus.mdata_r) * h_old_q[rd_idx_q[JW-1:0]];
    acc_d  = acc_q;
    case (rd_sel_q)
      SEL_B1:  acc_d = rd_ext <<< FRAC;
      SEL_W:   acc_d = acc_q + ACC_W'(prod);
      SEL_U:   if (x_q[rd_idx_q[KW-1:0]]) acc_d = acc_q + (rd_ext <<< FRAC);
      SEL_B2:  acc_d = acc_q + (rd_ext <<< FRAC);
      default: acc_d = acc_q;
    endcase
`ifdef RNN_ROUND_EN
    acc_r = acc_q + (ACC_W'(1) <<< (FRAC - 1));
`else
    acc_r = acc_q;
`endif
    y_full = acc_r >>> FRAC;
    if (y_full > ONE)       y = ONE_DW;
    else if (y_full < -ONE) y = NEG_ONE_DW;
    else                    y = y_full[DW-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q    <= '0;
      rd_sel_q <= SEL_T;
      rd_idx_q <= '0;
    end else begin
      acc_q    <= acc_d;
      rd_sel_q <= msel_q;
      rd_idx_q <= cnt_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      i_en_q    <= 1'b0;
      maddr_q   <= '0;
      msel_q    <= SEL_T;
      mdata_w_q <= '0;
      t_q       <= '0;
      t_max_q   <= '0;
      j_q       <= '0;
      cnt_q     <= '0;
      wb_cnt_q  <= '0;
      x_q       <= '0;
      // NOTE: the hidden-state arrays are architectural (h_0 = 0), so they are reset too.
      for (int n = 0; n < HID; n++) begin
        h_old_q[n] <= '0;
        h_new_q[n] <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: if (bus.ready) begin
          busy_q  <= 1'b1;
          state_q <= S_LDT;
          msel_q  <= SEL_T;
          maddr_q <= '0;
          t_q     <= '0;
          for (int n = 0; n < HID; n++) h_old_q[n] <= '0;  // each run starts from h_0 = 0
        end
        S_LDT: state_q <= S_LDW;
        S_LDW: begin
          t_max_q <= bus.mdata_r[TW-1:0];
          if (bus.mdata_r[TW-1:0] == '0) state_q <= S_DONE;
          else begin
            state_q <= S_GETX;
            i_en_q  <= 1'b1;
          end
        end
        S_GETX: begin
          i_en_q  <= 1'b0;
          state_q <= S_XW;
        end
        S_XW: begin
          x_q     <= bus.idata;
          j_q     <= '0;
          msel_q  <= SEL_B1;
          maddr_q <= '0;
          state_q <= S_B1;
        end
        S_B1: begin
          cnt_q   <= '0;
          msel_q  <= SEL_W;
          maddr_q <= AW'({j_q, {JW{1'b0}}});
          state_q <= S_MW;
        end
        S_MW: if (cnt_q == IW'(HID - 1)) begin
          cnt_q   <= '0;
          msel_q  <= SEL_U;
          maddr_q <= AW'({j_q, {KW{1'b0}}});
          state_q <= S_MU;
        end else begin
          cnt_q   <= cnt_inc;
          maddr_q <= AW'({j_q, cnt_inc[JW-1:0]});
        end
        S_MU: if (cnt_q == IW'(XBITS - 1)) begin
          msel_q  <= SEL_B2;
          maddr_q <= AW'(j_q);
          state_q <= S_B2;
        end else begin
          cnt_q   <= cnt_inc;
          maddr_q <= AW'({j_q, cnt_inc[KW-1:0]});
        end
        S_B2: begin
          wb_cnt_q <= '0;
          msel_q   <= SEL_T;
          maddr_q  <= '0;
          state_q  <= S_WB;
        end
        S_WB: begin
          wb_cnt_q <= wb_cnt_q + 1'b1;
          if (wb_cnt_q == 2'd1) begin
            msel_q       <= SEL_OUT;
            maddr_q      <= AW'({t_q, j_q});
            mdata_w_q    <= y;
            h_new_q[j_q] <= y;
          end else if (wb_cnt_q == 2'd2) begin
            msel_q  <= SEL_T;
            maddr_q <= '0;
            if (j_q != JW'(HID - 1)) begin
              j_q     <= j_q + 1'b1;
              msel_q  <= SEL_B1;
              maddr_q <= AW'(j_q + 1'b1);
              state_q <= S_B1;
            end else begin
              h_old_q <= h_new_q;
              t_q     <= t_inc;
              if (t_inc == t_max_q) state_q <= S_DONE;
              else begin
                state_q <= S_GETX;
                i_en_q  <= 1'b1;
              end
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          msel_q  <= SEL_T;
          maddr_q <= '0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rnn_cell_engine.sv
// Directed bench for rnn_cell_engine at HID=4, XBITS=4, DW=20, FRAC=16 with a
// behavioural 1-cycle-latency SRAM and input streamer.
module tb_rnn_cell_engine;
  localparam int HID = 4, XBITS = 4, DW = 20, FRAC = 16, AW = 17, TW = 11;
  localparam int ROW_CYC  = HID + XBITS + 5;
  localparam int STEP_CYC = 2 + HID * ROW_CYC;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  rnn_cell_engine_if #(.XBITS(XBITS), .DW(DW), .AW(AW)) bus ();

  rnn_cell_engine #(.HID(HID), .XBITS(XBITS), .DW(DW), .FRAC(FRAC), .AW(AW), .TW(TW))
    dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  logic [DW-1:0]    mem_u [16];
  logic [DW-1:0]    mem_w [16];
  logic [DW-1:0]    mem_b1[4];
  logic [DW-1:0]    mem_b2[4];
  logic [DW-1:0]    t_cnt;
  logic [XBITS-1:0] x_vec [4];

  int total = 0, bad = 0;
  int busy_cycles = 0, ien_cnt = 0, mce_err = 0;
  int b0 = 0, i0 = 0, w0 = 0, m0 = 0;
  logic [AW-1:0] wr_addr[$];
  logic [DW-1:0] wr_data[$];
  logic [AW-1:0] exp_a[8];
  logic [DW-1:0] exp_d[8];

  // SRAM: address and bank sampled at the edge, data valid for the next cycle.
  always @(posedge clk) begin
    case (bus.msel)
      3'b000:  bus.mdata_r <= mem_u[bus.maddr[3:0]];
      3'b001:  bus.mdata_r <= mem_b1[bus.maddr[1:0]];
      3'b010:  bus.mdata_r <= mem_w[bus.maddr[3:0]];
      3'b011:  bus.mdata_r <= mem_b2[bus.maddr[1:0]];
      3'b100:  bus.mdata_r <= t_cnt;
      default: bus.mdata_r <= '0;
    endcase
  end

  // Monitor and input streamer, sampling mid-cycle.
  always @(negedge clk) begin
    if (bus.busy === 1'b1) busy_cycles++;
    if (bus.mce !== bus.busy) mce_err++;
    if (bus.i_en === 1'b1) begin
      bus.idata = x_vec[(ien_cnt - i0) % 4];
      ien_cnt++;
    end
    if (bus.msel === 3'b101) begin
      wr_addr.push_back(bus.maddr);
      wr_data.push_back(bus.mdata_w);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) begin
      mem_u[i] = '0;
      mem_w[i] = '0;
    end
    for (int i = 0; i < 4; i++) begin
      mem_b1[i] = '0;
      mem_b2[i] = '0;
      x_vec[i]  = '0;
    end
    t_cnt = '0;
  endtask

  task automatic snapshot();
    b0 = busy_cycles;
    i0 = ien_cnt;
    w0 = wr_data.size();
    m0 = mce_err;
  endtask

  // Pulse ready, poke ready again mid-run (must be ignored), wait for busy to fall.
  task automatic start_and_wait(input int budget);
    int n;
    snapshot();
    @(negedge clk) bus.ready = 1'b1;
    @(negedge clk) bus.ready = 1'b0;
    n = 0;
    while (bus.busy === 1'b1) begin
      @(negedge clk);
      n++;
      if (n == 20) bus.ready = 1'b1;
      if (n == 21) bus.ready = 1'b0;
      if (n > budget) begin
        check("busy_timeout", 32'd0, 32'd1);
        break;
      end
    end
  endtask

  task automatic check_run(input string name, input int exp_busy, input int exp_ien,
                           input int exp_nw);
    int nw;
    nw = wr_data.size() - w0;
    check({name, "_busy_cycles"}, busy_cycles - b0, exp_busy);
    check({name, "_ien_pulses"}, ien_cnt - i0, exp_ien);
    check({name, "_mce_eq_busy"}, mce_err - m0, 0);
    check({name, "_writes"}, nw, exp_nw);
    for (int i = 0; i < exp_nw && i < nw; i++) begin
      check($sformatf("%s_addr%0d", name, i), wr_addr[w0+i], exp_a[i]);
      check($sformatf("%s_data%0d", name, i), wr_data[w0+i], exp_d[i]);
    end
  endtask

  task automatic cfg_identity();
    clear_mem();
    t_cnt     = 20'd2;
    mem_w[0]  = 20'h10000;
    mem_w[5]  = 20'h10000;
    mem_w[10] = 20'h10000;
    mem_w[15] = 20'h10000;
    mem_w[4]  = 20'h10000;   // W[1][0]: exposes an early h_old update
    mem_b1[0] = 20'h04000;
    for (int i = 0; i < 8; i++) begin
      exp_a[i] = AW'(i);
      exp_d[i] = '0;
    end
    exp_d[0] = 20'h04000;
    exp_d[4] = 20'h08000;
    exp_d[5] = 20'h04000;
  endtask

  initial begin
    int n;
    reset_n   = 1'b0;
    bus.ready = 1'b0;
    clear_mem();
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_i_en", bus.i_en, 0);
    check("rst_mce", bus.mce, 0);
    check("rst_maddr", bus.maddr, 0);
    check("rst_msel", bus.msel, 3'b100);
    check("rst_mdata_w", bus.mdata_w, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // All-zero weights, T=1.
    clear_mem();
    t_cnt = 20'd1;
    for (int i = 0; i < 4; i++) begin
      exp_a[i] = AW'(i);
      exp_d[i] = '0;
    end
    start_and_wait(1000);
    check_run("zero", 3 + STEP_CYC, 1, 4);

    // T=0: no input request, no writes, short busy window.
    clear_mem();
    start_and_wait(1000);
    check("t0_busy_le4", ((busy_cycles - b0) <= 4) && ((busy_cycles - b0) > 0), 1);
    check("t0_ien_pulses", ien_cnt - i0, 0);
    check("t0_writes", wr_data.size() - w0, 0);

    // Saturation: 0.5 + 4*0.25 + 0.5 = 2.0 clamps to +1.0, negated to -1.0.
    clear_mem();
    t_cnt = 20'd1;
    x_vec[0] = 4'hF;
    for (int i = 0; i < 16; i++) mem_u[i] = 20'h04000;
    for (int i = 0; i < 4; i++) begin
      mem_b1[i] = 20'h08000;
      mem_b2[i] = 20'h08000;
      exp_a[i]  = AW'(i);
      exp_d[i]  = 20'h10000;
    end
    start_and_wait(1000);
    check_run("sat_pos", 3 + STEP_CYC, 1, 4);

    for (int i = 0; i < 16; i++) mem_u[i] = 20'hFC000;
    for (int i = 0; i < 4; i++) begin
      mem_b1[i] = 20'hF8000;
      mem_b2[i] = 20'hF8000;
      exp_d[i]  = 20'hF0000;
    end
    start_and_wait(1000);
    check_run("sat_neg", 3 + STEP_CYC, 1, 4);

    // Recurrence over two steps, h_old swapped only after the last row.
    cfg_identity();
    start_and_wait(1000);
    check_run("recur", 3 + 2 * STEP_CYC, 2, 8);

    // Output scaling at exactly half an LSB, positive and negative.
    clear_mem();
    t_cnt    = 20'd2;
    x_vec[0] = 4'h1;
    x_vec[1] = 4'h0;
    mem_u[0] = 20'h08000;
    mem_w[0] = 20'h00001;
    mem_w[4] = 20'hFFFFF;
    for (int i = 0; i < 8; i++) begin
      exp_a[i] = AW'(i);
      exp_d[i] = '0;
    end
    exp_d[0] = 20'h08000;
`ifdef RNN_ROUND_EN
    exp_d[4] = 20'h00001;
    exp_d[5] = 20'h00000;
`else
    exp_d[4] = 20'h00000;
    exp_d[5] = 20'hFFFFF;
`endif
    start_and_wait(1000);
    check_run("scale", 3 + 2 * STEP_CYC, 2, 8);

    // Asynchronous abort during MW of row 1, then a clean restart.
    clear_mem();
    t_cnt    = 20'd1;
    x_vec[0] = 4'hF;
    for (int i = 0; i < 16; i++) mem_u[i] = 20'h04000;
    for (int i = 0; i < 4; i++) begin
      mem_b1[i] = 20'h08000;
      mem_b2[i] = 20'h08000;
    end
    snapshot();
    @(negedge clk) bus.ready = 1'b1;
    @(negedge clk) bus.ready = 1'b0;
    n = 0;
    while (!((wr_data.size() - w0) >= 1 && bus.msel === 3'b010) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("abort_reached_mw", n < 500, 1);
    reset_n = 1'b0;
    #1;
    check("abort_busy", bus.busy, 0);
    check("abort_i_en", bus.i_en, 0);
    check("abort_mce", bus.mce, 0);
    check("abort_maddr", bus.maddr, 0);
    check("abort_msel", bus.msel, 3'b100);
    check("abort_mdata_w", bus.mdata_w, 0);
    repeat (3) @(negedge clk);
    check("abort_writes", wr_data.size() - w0, 1);
    reset_n = 1'b1;
    @(negedge clk);

    cfg_identity();
    start_and_wait(1000);
    check_run("restart", 3 + 2 * STEP_CYC, 2, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
